// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
//   H_RES / V_RES : visible resolution used for clipping
//   X_W / Y_W / C_W : pixel coordinate and colour widths
//   FB_ADDR_W : linear framebuffer word address width
//   KEY_COLOR : colour treated as transparent when TRANSPARENT_KEY_EN is defined
//   out_state_t : output stage states
//   fb_addr_of() : linear address y*320 + x built from shifts
package fb_pkg;

    localparam int unsigned X_W       = 9;
    localparam int unsigned Y_W       = 8;
    localparam int unsigned C_W       = 12;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned DEPTH     = 8;

    localparam logic [X_W-1:0] H_RES     = 9'd320;
    localparam logic [Y_W-1:0] V_RES     = 8'd240;
    localparam logic [C_W-1:0] KEY_COLOR = 12'h000;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    // y*320 = y*256 + y*64; fits 17 bits for every in-range pixel.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input logic [X_W-1:0] x,
                                                        input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = FB_ADDR_W'(y);
        return (yw << 8) + (yw << 6) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for pixel entries.
//   clk, reset        : clock, synchronous active-high reset (flushes contents)
//   push, wdata       : write an entry (ignored when full)
//   pop, rdata        : remove head entry (ignored when empty); rdata shows the head
//   full, empty, level: status decoded from the extra-MSB pointers
module pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 29
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PTR_ONE;
            if (pop && !empty)
                rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    // Same index with differing wrap bits means the write side lapped the read side.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign level = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/pixel_fb_writer.sv
// Framebuffer pixel writer: clips incoming pixel writes, buffers them in a
// FIFO and presents them one at a time on the framebuffer write port.
// Optional feature macro: TRANSPARENT_KEY_EN (drop in-range KEY_COLOR pixels).
//   clk, reset            : clock, synchronous active-high reset
//   in_x/in_y/in_color    : pixel to write, qualified by in_we
//   in_ready              : FIFO not full this cycle
//   fb_addr/fb_data/fb_we : framebuffer write port, held until fb_grant
//   fb_grant              : port accepts the pending write this cycle
//   level                 : FIFO occupancy (excludes the write held on the port)
//   idle                  : nothing buffered and nothing pending
//   overflow              : sticky, an in-range pixel was dropped on a full FIFO
//   clip_cnt              : saturating count of out-of-range pixels
module pixel_fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8:0]                    in_x,
    input  logic [7:0]                    in_y,
    input  logic [11:0]                   in_color,
    input  logic                          in_we,
    output logic                          in_ready,
    output logic [16:0]                   fb_addr,
    output logic [11:0]                   fb_data,
    output logic                          fb_we,
    input  logic                          fb_grant,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          idle,
    output logic                          overflow,
    output logic [15:0]                   clip_cnt
);

    out_state_t state;
    out_state_t state_nxt;

    pixel_t     in_px;
    pixel_t     head_px;
    logic [$bits(pixel_t)-1:0] head_raw;
    logic       full;
    logic       empty;
    logic       clipped;
    logic       keyed;
    logic       push;
    logic       pop;

    assign in_px   = '{x: in_x, y: in_y, color: in_color};
    assign clipped = (in_x >= H_RES) || (in_y >= V_RES);

`ifdef TRANSPARENT_KEY_EN
    assign keyed = (in_color == KEY_COLOR);
`else
    assign keyed = 1'b0;
`endif

    // Clipping wins over keying and overflow; only surviving pixels see the full flag.
    assign push     = in_we && !clipped && !keyed && !full;
    assign in_ready = !full;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(pixel_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_px),
        .pop   (pop),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign head_px = pixel_t'(head_raw);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fb_grant) begin
                    if (!empty)
                        pop = 1'b1;
                    else
                        state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            fb_addr  <= '0;
            fb_data  <= '0;
            overflow <= 1'b0;
            clip_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                fb_addr <= fb_addr_of(head_px.x, head_px.y);
                fb_data <= head_px.color;
            end
            if (in_we && clipped && (clip_cnt != '1))
                clip_cnt <= clip_cnt + 16'd1;
            if (in_we && !clipped && !keyed && full)
                overflow <= 1'b1;
        end
    end

    assign fb_we = (state == ST_HOLD);
    assign idle  = empty && (state == ST_EMPTY);

endmodule

// File: tb/tb_pixel_fb_writer.sv
module tb_pixel_fb_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [11:0] in_color = '0;
    logic        in_we = 1'b0;
    logic        in_ready;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        fb_grant = 1'b0;
    logic [3:0]  level;
    logic        idle;
    logic        overflow;
    logic [15:0] clip_cnt;

    int unsigned n_checks = 0;
    int unsigned n_bad = 0;

    // Expected writes as {addr, data}, in push order.
    logic [28:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [16:0] prev_addr;
    logic [11:0] prev_data;

    always #5 clk = ~clk;

    pixel_fb_writer #(.FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_color (in_color),
        .in_we    (in_we),
        .in_ready (in_ready),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .fb_grant (fb_grant),
        .level    (level),
        .idle     (idle),
        .overflow (overflow),
        .clip_cnt (clip_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Port monitor: every granted write must match the scoreboard head,
    // and a stalled write must keep its address and data.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && fb_we) begin
                check("hold_addr", 32'(fb_addr), 32'(prev_addr));
                check("hold_data", 32'(fb_data), 32'(prev_data));
            end
            if (fb_we && fb_grant) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fb_addr), 32'h1FFFF);
                end else begin
                    logic [28:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e[28:12]));
                    check("wr_data", 32'(fb_data), 32'(e[11:0]));
                end
            end
            prev_stall <= fb_we && !fb_grant;
            prev_addr  <= fb_addr;
            prev_data  <= fb_data;
        end
    end

    function automatic logic [16:0] model_addr(input int unsigned x, input int unsigned y);
        return 17'(y * 320 + x);
    endfunction

    // Drive one pixel for exactly one cycle; caller states whether it must land.
    task automatic px(input int unsigned x, input int unsigned y, input logic [11:0] c,
                      input bit lands);
        in_x     = 9'(x);
        in_y     = 8'(y);
        in_color = c;
        in_we    = 1'b1;
        if (lands)
            exp_q.push_back({model_addr(x, y), c});
        @(posedge clk);
        #1;
        in_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fb_we",    32'(fb_we),    32'd0);
        check("rst_fb_addr",  32'(fb_addr),  32'd0);
        check("rst_fb_data",  32'(fb_data),  32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_idle",     32'(idle),     32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_clip_cnt", 32'(clip_cnt), 32'd0);

        // Single pixel, latency N+2
        @(posedge clk);
        #1 fb_grant = 1'b1;
        px(10, 20, 12'hF80, 1'b1);
        @(negedge clk);
        check("lat_n1_fb_we", 32'(fb_we), 32'd0);
        @(negedge clk);
        check("lat_n2_fb_we", 32'(fb_we), 32'd1);
        check("single_addr",  32'(fb_addr), 32'd6410);
        check("single_data",  32'(fb_data), 32'hF80);
        @(negedge clk);
        check("single_one_cycle", 32'(fb_we), 32'd0);
        check("single_idle",      32'(idle),  32'd1);
        check("single_q", 32'(exp_q.size()), 32'd0);

        // Burst with no grant: one write parks on the port, eight fill the FIFO
        @(posedge clk);
        #1 fb_grant = 1'b0;
        for (int i = 0; i < 9; i++)
            px(i * 7, i + 1, 12'(12'h100 + i), 1'b1);
        @(negedge clk);
        check("burst_level",    32'(level),    32'd8);
        check("burst_in_ready", 32'(in_ready), 32'd0);
        check("burst_fb_we",    32'(fb_we),    32'd1);
        check("burst_no_ovf",   32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        px(100, 100, 12'hABC, 1'b0);
        @(negedge clk);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_level2",   32'(level),    32'd8);
        @(posedge clk);
        #1 fb_grant = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("b2b_fb_we", 32'(fb_we), 32'd1);
        end
        drain("burst_drain");

        // Clipping boundaries
        px(320, 0,   12'h123, 1'b0);
        px(0,   240, 12'h456, 1'b0);
        px(319, 239, 12'h789, 1'b1);
        @(negedge clk);
        check("clip_cnt", 32'(clip_cnt), 32'd2);
        drain("clip_drain");
        check("clip_last_addr", 32'(fb_addr), 32'd76799);

        // Grant toggling during a stream
        fork
            begin
                for (int i = 0; i < 5; i++)
                    px(40 + i, 50 + i * 3, 12'(12'h0A0 + i * 17), 1'b1);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    @(posedge clk);
                    #1 fb_grant = ~fb_grant;
                end
            end
        join
        #1 fb_grant = 1'b1;
        drain("toggle_drain");

        // Reset with a write pending and level=5
        @(posedge clk);
        #1 fb_grant = 1'b0;
        for (int i = 0; i < 6; i++)
            px(200 + i, 10, 12'h555, 1'b1);
        @(negedge clk);
        check("pre_rst_level", 32'(level), 32'd5);
        check("pre_rst_fb_we", 32'(fb_we), 32'd1);
        do_reset();
        @(negedge clk);
        check("mid_rst_fb_we",    32'(fb_we),    32'd0);
        check("mid_rst_level",    32'(level),    32'd0);
        check("mid_rst_idle",     32'(idle),     32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_clip_cnt", 32'(clip_cnt), 32'd0);

        // Black pixel
        @(posedge clk);
        #1 fb_grant = 1'b1;
`ifdef TRANSPARENT_KEY_EN
        px(5, 5, 12'h000, 1'b0);
        repeat (4) @(negedge clk);
        check("key_no_write_idle", 32'(idle),     32'd1);
        check("key_no_clip",       32'(clip_cnt), 32'd0);
        check("key_no_ovf",        32'(overflow), 32'd0);
        check("key_q", 32'(exp_q.size()), 32'd0);
`else
        px(5, 5, 12'h000, 1'b1);
        drain("black_drain");
        check("black_addr", 32'(fb_addr), 32'd1605);
        check("black_data", 32'(fb_data), 32'h000);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
